rw_mode_scheduler: RTL and testbench
====================================

RW_MODE_SCHEDULER -- requirements
Module: rw_mode_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WR_HIGH_WM, 12: write occupancy that forces a switch to write drain.
- WR_LOW_WM, 4: write occupancy at which a drain may end.
- TURNAROUND, 4: idle bus cycles on every direction change.
- STARVE_LIMIT, 64: cycles of write waiting tolerated in read mode.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: reset; synchronous, active-high.
- rd_pending, in, read_entries_log+1: reads currently buffered.
- wr_pending, in, write_entries_log+1: writes currently buffered.
- issue_ready, in, 1: back end accepts a command this cycle.
- issue_valid, out, 1: a command is offered this cycle.
- issue_type, out, req_type_t: read or write for the offered command.
- rd_pop, out, 1: dequeue strobe to the read queue.
- wr_pop, out, 1: dequeue strobe to the write queue.
- mode, out, sched_mode_t: current FSM state, registered.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.

Function
REQ-004 FSM states: READ, TURN_R2W, WR_DRAIN, TURN_W2R; the state is the mode output.
REQ-005 issue_valid, issue_type, rd_pop and wr_pop are combinational from state and inputs; the next state registers on the edge.
REQ-006 READ state:
- issue_valid = (rd_pending != 0); issue_type = read.
- rd_pop = issue_valid & issue_ready; wr_pop = 0.
REQ-007 WR_DRAIN state:
- issue_valid = (wr_pending != 0); issue_type = write.
- wr_pop = issue_valid & issue_ready; rd_pop = 0.
REQ-008 TURN states: issue_valid = 0, rd_pop = 0, wr_pop = 0, regardless of inputs.
REQ-009 READ -> TURN_R2W when any of the following holds:
- wr_pending >= WR_HIGH_WM;
- rd_pending == 0 and wr_pending != 0;
- starve_cnt == STARVE_LIMIT and wr_pending != 0.
REQ-010 WR_DRAIN -> TURN_W2R when either holds:
- wr_pending == 0;
- wr_pending <= WR_LOW_WM and rd_pending != 0.
REQ-011 The read/write issued in a cycle whose exit condition is true SHALL still complete (pop asserted if ready); the state changes on the next edge.
REQ-012 Turnaround counter:
- loads TURNAROUND-1 on entry to either TURN state and decrements each cycle;
- at 0, TURN_R2W -> WR_DRAIN and TURN_W2R -> READ;
- each TURN state therefore lasts exactly TURNAROUND cycles.
REQ-013 starve_cnt:
- increments each READ cycle with wr_pending != 0;
- saturates at STARVE_LIMIT;
- clears when wr_pending == 0 or on entry to WR_DRAIN;
- width clog2(STARVE_LIMIT+1).
REQ-014 Idle rules:
- READ with both counts 0 stays in READ with no issue.
- WR_DRAIN never idles; it exits via REQ-010.
REQ-015 issue_ready low SHALL block pops only; state, turnaround and starvation logic keep advancing.
REQ-016 A command is never offered from an empty queue; pop asserts only when the matching pending count is nonzero.
REQ-017 Parameter legality is checked at elaboration: WR_LOW_WM < WR_HIGH_WM <= write_entries, TURNAROUND >= 1, STARVE_LIMIT >= 1.

Reset
REQ-018 While rst is high:
- state = READ, starve_cnt = 0, turnaround counter = 0;
- all pops 0 and issue_valid = 0, overriding REQ-006;
- mode = READ.
REQ-019 Reset asserted mid-turnaround or mid-drain SHALL abandon that operation; the first cycle after rst falls behaves as READ.

Structure
REQ-020 types_def SHALL hold:
- req_type_t (read, write);
- sched_mode_t (the four states);
- read_entries, write_entries, read_entries_log, write_entries_log.
REQ-021 The block SHALL be a single module with no sub-modules; the turnaround and starvation counters are inline.

Verification
REQ-022 rd_pending=5, wr_pending=0, ready=1 for 5 cycles -> 5 rd_pop pulses, mode stays READ, wr_pop never asserts.
REQ-023 wr_pending steps to 12 during reads -> next cycle mode = TURN_R2W for exactly 4 cycles with no issue, then WR_DRAIN with wr_pop each ready cycle.
REQ-024 Drain with rd_pending=3, wr_pending falling 12 to 4 -> TURN_W2R on the edge after the count reaches 4, then READ after 4 cycles.
REQ-025 rd_pending held at 8, wr_pending=1 constant -> switch to TURN_R2W after 64 READ cycles; starve_cnt is 0 in WR_DRAIN.
REQ-026 issue_ready=0 throughout WR_DRAIN with wr_pending=2 -> no pops, state holds WR_DRAIN.
REQ-027 rst=1 during the second TURN_R2W cycle -> next cycle mode = READ, all outputs 0; after release, reads issue normally.

Source files
------------

// File: rtl/types_def.sv
// Shared types and queue geometry for the read/write mode scheduler.
// The read and write queue depths fix the width of the pending-count ports.
package types_def;

    localparam int read_entries      = 16;
    localparam int write_entries     = 16;
    localparam int read_entries_log  = $clog2(read_entries);
    localparam int write_entries_log = $clog2(write_entries);

    typedef enum logic {
        REQ_READ,
        REQ_WRITE
    } req_type_t;

    typedef enum logic [1:0] {
        READ,
        TURN_R2W,
        WR_DRAIN,
        TURN_W2R
    } sched_mode_t;

endpackage

// File: rtl/rw_mode_scheduler.sv
// Read/write direction scheduler: serves reads, drains writes in bursts,
// and inserts fixed idle turnaround gaps on every bus direction change.
module rw_mode_scheduler
    import types_def::*;
#(
    parameter int WR_HIGH_WM   = 12,
    parameter int WR_LOW_WM    = 4,
    parameter int TURNAROUND   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [read_entries_log:0]   rd_pending,
    input  logic [write_entries_log:0]  wr_pending,
    input  logic                        issue_ready,
    output logic                        issue_valid,
    output req_type_t                   issue_type,
    output logic                        rd_pop,
    output logic                        wr_pop,
    output sched_mode_t                 mode
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int TURN_W   = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [write_entries_log:0] WR_HIGH_C   = (write_entries_log + 1)'(WR_HIGH_WM);
    localparam logic [write_entries_log:0] WR_LOW_C    = (write_entries_log + 1)'(WR_LOW_WM);
    localparam logic [STARVE_W-1:0]        STARVE_MAX  = STARVE_W'(STARVE_LIMIT);
    localparam logic [TURN_W-1:0]          TURN_LOAD   = TURN_W'(TURNAROUND - 1);

    if (!(WR_LOW_WM < WR_HIGH_WM && WR_HIGH_WM <= write_entries &&
          TURNAROUND >= 1 && STARVE_LIMIT >= 1)) begin : g_param_check
        $error("rw_mode_scheduler: illegal watermark/turnaround/starvation parameters");
    end

    sched_mode_t         state, state_next;
    logic [TURN_W-1:0]   turn_cnt, turn_cnt_next;
    logic [STARVE_W-1:0] starve_cnt, starve_cnt_next;
    logic                rd_any, wr_any;

    assign rd_any = (rd_pending != '0);
    assign wr_any = (wr_pending != '0);
    assign mode   = state;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next      = state;
        turn_cnt_next   = turn_cnt;
        starve_cnt_next = starve_cnt;
        issue_valid     = 1'b0;
        issue_type      = REQ_READ;
        rd_pop          = 1'b0;
        wr_pop          = 1'b0;

        unique case (state)
            READ: begin
                issue_valid = rd_any;
                rd_pop      = rd_any & issue_ready;
                if (!wr_any)
                    starve_cnt_next = '0;
                else if (starve_cnt != STARVE_MAX)
                    starve_cnt_next = starve_cnt + 1'b1;
                if (wr_pending >= WR_HIGH_C || (!rd_any && wr_any) ||
                    (starve_cnt == STARVE_MAX && wr_any)) begin
                    state_next    = TURN_R2W;
                    turn_cnt_next = TURN_LOAD;
                end
            end
            TURN_R2W: begin
                if (!wr_any)
                    starve_cnt_next = '0;
                if (turn_cnt == '0) begin
                    state_next      = WR_DRAIN;
                    starve_cnt_next = '0;
                end else begin
                    turn_cnt_next = turn_cnt - 1'b1;
                end
            end
            WR_DRAIN: begin
                issue_valid = wr_any;
                issue_type  = REQ_WRITE;
                wr_pop      = wr_any & issue_ready;
                if (!wr_any)
                    starve_cnt_next = '0;
                // The pop above still completes in the cycle the drain decides to end.
                if (!wr_any || (wr_pending <= WR_LOW_C && rd_any)) begin
                    state_next    = TURN_W2R;
                    turn_cnt_next = TURN_LOAD;
                end
            end
            TURN_W2R: begin
                if (!wr_any)
                    starve_cnt_next = '0;
                if (turn_cnt == '0)
                    state_next = READ;
                else
                    turn_cnt_next = turn_cnt - 1'b1;
            end
            default: state_next = READ;
        endcase

        if (rst) begin
            issue_valid = 1'b0;
            rd_pop      = 1'b0;
            wr_pop      = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= READ;
            turn_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            turn_cnt   <= turn_cnt_next;
            starve_cnt <= starve_cnt_next;
        end
    end

endmodule

// File: tb/tb_rw_mode_scheduler.sv
// Scoreboard bench for rw_mode_scheduler: directed scenarios plus random traffic,
// checked cycle by cycle against a direction/turn-gap reference model.
module tb_rw_mode_scheduler;
    import types_def::*;

    localparam int HIGH   = 12;
    localparam int LOW    = 4;
    localparam int TURN   = 4;
    localparam int STARVE = 64;

    typedef struct {
        sched_mode_t mode;
        bit          valid;
        req_type_t   itype;
        bit          rd_pop;
        bit          wr_pop;
    } expect_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [read_entries_log:0]  rd_pending = '0;
    logic [write_entries_log:0] wr_pending = '0;
    logic                       issue_ready = 1'b0;
    logic                       issue_valid;
    req_type_t                  issue_type;
    logic                       rd_pop;
    logic                       wr_pop;
    sched_mode_t                mode;

    rw_mode_scheduler #(
        .WR_HIGH_WM  (HIGH),
        .WR_LOW_WM   (LOW),
        .TURNAROUND  (TURN),
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_pending (rd_pending),
        .wr_pending (wr_pending),
        .issue_ready(issue_ready),
        .issue_valid(issue_valid),
        .issue_type (issue_type),
        .rd_pop     (rd_pop),
        .wr_pop     (wr_pop),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;
    expect_t sb[$];
    bit record = 0;

    // Reference model: which direction the bus is headed, how many idle gap
    // cycles remain before it gets there, and how long writes have waited.
    bit m_to_write  = 0;
    int m_turn_left = 0;
    int m_starve    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic sched_mode_t model_mode();
        if (m_turn_left > 0) return m_to_write ? TURN_R2W : TURN_W2R;
        return m_to_write ? WR_DRAIN : READ;
    endfunction

    task automatic step(input bit r, input int rd, input int wr, input bit rdy);
        expect_t e;
        bit serving_rd, serving_wr, leave;
        @(posedge clk);
        #1;
        rst         = r;
        rd_pending  = (read_entries_log + 1)'(rd);
        wr_pending  = (write_entries_log + 1)'(wr);
        issue_ready = rdy;

        serving_rd = !m_to_write && m_turn_left == 0;
        serving_wr =  m_to_write && m_turn_left == 0;
        e.mode   = model_mode();
        e.valid  = 0;
        e.itype  = REQ_READ;
        e.rd_pop = 0;
        e.wr_pop = 0;
        if (!r && serving_rd) begin
            e.valid  = (rd != 0);
            e.rd_pop = e.valid && rdy;
        end else if (!r && serving_wr) begin
            e.valid  = (wr != 0);
            e.itype  = REQ_WRITE;
            e.wr_pop = e.valid && rdy;
        end
        if (record) sb.push_back(e);

        if (r) begin
            m_to_write = 0; m_turn_left = 0; m_starve = 0;
        end else if (m_turn_left > 0) begin
            m_turn_left--;
            if (wr == 0 || (m_turn_left == 0 && m_to_write)) m_starve = 0;
        end else if (serving_rd) begin
            leave = (wr >= HIGH) || (rd == 0 && wr != 0) || (m_starve == STARVE && wr != 0);
            m_starve = (wr == 0) ? 0 : ((m_starve < STARVE) ? m_starve + 1 : STARVE);
            if (leave) begin m_to_write = 1; m_turn_left = TURN; end
        end else begin
            if (wr == 0) m_starve = 0;
            if (wr == 0 || (wr <= LOW && rd != 0)) begin m_to_write = 0; m_turn_left = TURN; end
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            expect_t e;
            e = sb.pop_front();
            check("mode",        32'(mode),        32'(e.mode));
            check("issue_valid", 32'(issue_valid), 32'(e.valid));
            check("rd_pop",      32'(rd_pop),      32'(e.rd_pop));
            check("wr_pop",      32'(wr_pop),      32'(e.wr_pop));
            if (e.valid) check("issue_type", 32'(issue_type), 32'(e.itype));
        end
    end

    initial begin
        repeat (2) step(1, 0, 0, 1);
        record = 1;

        // Pure reads with no writes buffered.
        step(0, 0, 0, 1);
        repeat (5) step(0, 5, 0, 1);

        // Write occupancy climbs to the high watermark, then drains down to LOW.
        repeat (2) step(0, 5, 11, 1);
        step(0, 5, 12, 1);
        repeat (TURN) step(0, 3, 12, 1);
        for (int w = 12; w >= 4; w--) step(0, 3, w, 1);
        repeat (TURN + 3) step(0, 3, 2, 1);

        // Steady trickle of one write behind a read backlog: starvation path.
        step(1, 0, 0, 1);
        repeat (STARVE + 2 + TURN + 4) step(0, 8, 1, 1);

        // Drain with the back end stalled.
        step(1, 0, 0, 1);
        repeat (1 + TURN) step(0, 0, 2, 1);
        repeat (10) step(0, 0, 2, 0);

        // Reset during the second turnaround cycle, then normal reads.
        step(1, 0, 0, 1);
        step(0, 0, 5, 1);
        step(0, 0, 5, 1);
        step(1, 0, 5, 1);
        repeat (4) step(0, 4, 0, 1);

        // Random traffic with occasional resets.
        begin
            int rd = 0, wr = 0;
            bit r, rdy;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) rd = $urandom_range(0, read_entries);
                if ($urandom_range(0, 3) == 0) wr = $urandom_range(0, write_entries);
                rdy = ($urandom_range(0, 3) != 0);
                r   = ($urandom_range(0, 299) == 0);
                step(r, rd, wr, rdy);
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
